iob_soc_opencryptolinux_pbus_split: RTL and testbench

//  Parametrised IOb peripheral-bus splitter with error handling; next generation of the plain pbus split behind axil2iob.

---
 rtl/iob_soc_opencryptolinux_pbus_split.sv | 240 ++++++++++++++++++++++++
 tb/tb_iob_soc_opencryptolinux_pbus_split.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_soc_opencryptolinux_pbus_split.sv
// IOb peripheral-bus splitter: address-decoded routing of one master to N slaves,
// with unmapped-select, accept-timeout and response-timeout error handling.
module iob_soc_opencryptolinux_pbus_split #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                N_SLAVES = 4,
    parameter int                SEL_MSB  = ADDR_W - 2,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF),
    parameter int                ERRCNT_W = 16
) (
    input  logic                                        clk_i,
    input  logic                                        arst_i,
    input  logic                                        cke_i,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0]             m_req_i,
    output logic [DATA_W+1:0]                           m_resp_o,
    output logic [N_SLAVES*(1+ADDR_W+DATA_W+DATA_W/8)-1:0] s_req_o,
    input  logic [N_SLAVES*(DATA_W+2)-1:0]              s_resp_i,
    output logic                                        err_o,
    output logic [1:0]                                  err_code_o,
    output logic [ADDR_W-1:0]                           err_addr_o,
    output logic [ERRCNT_W-1:0]                         err_cnt_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
    localparam int RSP_W  = DATA_W + 2;
    localparam int SEL_W  = $clog2(N_SLAVES);
    localparam int TMR_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TO_EN  = TIMEOUT > 0;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] CODE_UNMAP = 2'b01;
    localparam logic [1:0] CODE_ACC   = 2'b10;
    localparam logic [1:0] CODE_RSP   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        ERR_RSP
    } state_t;

    logic                m_avalid;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [STRB_W-1:0]   m_wstrb;
    logic                is_rd;

    logic [N_SLAVES-1:0] s_ready;
    logic [N_SLAVES-1:0] s_rvalid;
    logic [DATA_W-1:0]   s_rdata [N_SLAVES];
    logic [N_SLAVES-1:0] s_avalid;

    logic [SEL_W-1:0]    sel;
    logic [31:0]         sel_ext;
    logic                mapped;
    logic                sel_ready;
    logic                q_rvalid;
    logic [DATA_W-1:0]   q_rdata;

    logic                m_ready;
    logic                m_rvalid;
    logic [DATA_W-1:0]   m_rdata;

    logic                err_ev;
    logic [1:0]          ev_code;
    logic [ADDR_W-1:0]   ev_addr;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                err_q, err_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    assign m_avalid = m_req_i[REQ_W-1];
    assign m_addr   = m_req_i[REQ_W-2 -: ADDR_W];
    assign m_wdata  = m_req_i[DATA_W+STRB_W-1 -: DATA_W];
    assign m_wstrb  = m_req_i[STRB_W-1:0];
    assign is_rd    = (m_wstrb == '0);

    assign sel     = m_addr[SEL_MSB -: SEL_W];
    assign sel_ext = 32'(sel);
    assign mapped  = sel_ext < 32'(N_SLAVES);

    for (genvar k = 0; k < N_SLAVES; k++) begin : g_slv
        assign s_ready[k]  = s_resp_i[k*RSP_W];
        assign s_rvalid[k] = s_resp_i[k*RSP_W+1];
        assign s_rdata[k]  = s_resp_i[k*RSP_W+2 +: DATA_W];
        assign s_req_o[k*REQ_W +: REQ_W] = {s_avalid[k], m_addr, m_wdata, m_wstrb};
    end

    // Mux the decoded slave (request side) and the latched slave (response side)
    always_comb begin
        sel_ready = 1'b0;
        q_rvalid  = 1'b0;
        q_rdata   = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (sel_ext == 32'(k)) begin
                sel_ready = s_ready[k];
            end
            if (32'(sel_q) == 32'(k)) begin
                q_rvalid = s_rvalid[k];
                q_rdata  = s_rdata[k];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        timer_d  = timer_q;
        raddr_d  = raddr_q;
        s_avalid = '0;
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        err_ev   = 1'b0;
        ev_code  = 2'b00;
        ev_addr  = '0;

        unique case (state_q)
            IDLE: begin
                if (!m_avalid) begin
                    timer_d = '0;
                end else if (!mapped) begin
                    m_ready = 1'b1;
                    err_ev  = 1'b1;
                    ev_code = CODE_UNMAP;
                    ev_addr = m_addr;
                    if (is_rd) begin
                        state_d = ERR_RSP;
                    end
                end else if (TO_EN && !sel_ready && timer_q == TMR_LAST) begin
                    // Hung slave: complete the handshake ourselves
                    m_ready = 1'b1;
                    timer_d = '0;
                    err_ev  = 1'b1;
                    ev_code = CODE_ACC;
                    ev_addr = m_addr;
                    if (is_rd) begin
                        state_d = ERR_RSP;
                    end
                end else begin
                    for (int k = 0; k < N_SLAVES; k++) begin
                        s_avalid[k] = (sel_ext == 32'(k));
                    end
                    m_ready = sel_ready;
                    if (sel_ready) begin
                        timer_d = '0;
                        if (is_rd) begin
                            sel_d   = sel;
                            raddr_d = m_addr;
                            state_d = RD_WAIT;
                        end
                    end else if (TO_EN) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                m_rvalid = q_rvalid;
                m_rdata  = q_rvalid ? q_rdata : '0;
                if (q_rvalid) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else if (TO_EN && timer_q == TMR_LAST) begin
                    timer_d = '0;
                    err_ev  = 1'b1;
                    ev_code = CODE_RSP;
                    ev_addr = raddr_q;
                    state_d = ERR_RSP;
                end else if (TO_EN) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ERR_RSP: begin
                m_rvalid = 1'b1;
                m_rdata  = ERR_DATA;
                timer_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (arst_i) begin
            s_avalid = '0;
            m_ready  = 1'b0;
            m_rvalid = 1'b0;
            m_rdata  = '0;
        end
    end

    always_comb begin
        err_d      = err_ev;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (err_ev) begin
            err_code_d = ev_code;
            err_addr_d = ev_addr;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            timer_q    <= '0;
            raddr_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else if (cke_i) begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            timer_q    <= timer_d;
            raddr_q    <= raddr_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign m_resp_o   = {m_rdata, m_rvalid, m_ready};
    assign err_o      = err_q;
    assign err_code_o = err_code_q;
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_iob_soc_opencryptolinux_pbus_split.sv
// Scoreboard bench for the pbus splitter: driver models master and slaves,
// a negedge monitor checks read data and error records against queued expectations.
module tb_iob_soc_opencryptolinux_pbus_split;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NS     = 3;
    localparam int TO     = 16;
    localparam int ECW    = 4;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
    localparam int RSP_W  = DATA_W + 2;
    localparam logic [31:0] ERRD = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic arst_i;
    logic cke_i;
    logic [REQ_W-1:0] m_req_i;
    logic [RSP_W-1:0] m_resp_o;
    logic [NS*REQ_W-1:0] s_req_o;
    logic [NS*RSP_W-1:0] s_resp_i;
    logic err_o;
    logic [1:0] err_code_o;
    logic [ADDR_W-1:0] err_addr_o;
    logic [ECW-1:0] err_cnt_o;

    logic        m_avalid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [NS-1:0] s_ready;
    logic [NS-1:0] s_rvalid;
    logic [31:0] s_rdata [NS];

    logic        m_ready, m_rvalid;
    logic [31:0] m_rdata;
    logic [NS-1:0] s_av;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rq[$];
    logic [33:0] eq[$];
    int exp_cnt = 0;

    always #5 clk = ~clk;

    assign m_req_i = {m_avalid, m_addr, m_wdata, m_wstrb};
    assign m_ready  = m_resp_o[0];
    assign m_rvalid = m_resp_o[1];
    assign m_rdata  = m_resp_o[RSP_W-1:2];

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            s_resp_i[k*RSP_W +: RSP_W] = {s_rdata[k], s_rvalid[k], s_ready[k]};
            s_av[k] = s_req_o[k*REQ_W + REQ_W - 1];
        end
    end

    iob_soc_opencryptolinux_pbus_split #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLAVES(NS), .SEL_MSB(31),
        .TIMEOUT(TO), .ERR_DATA(ERRD), .ERRCNT_W(ECW)
    ) dut (
        .clk_i(clk), .arst_i(arst_i), .cke_i(cke_i),
        .m_req_i(m_req_i), .m_resp_o(m_resp_o),
        .s_req_o(s_req_o), .s_resp_i(s_resp_i),
        .err_o(err_o), .err_code_o(err_code_o),
        .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or error
    initial begin
        logic [31:0] er;
        logic [33:0] ee;
        forever begin
            @(negedge clk);
            if (arst_i) begin
                exp_cnt = 0;
            end else begin
                if (m_rvalid) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_rvalid", {32'd0, m_rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        er = rq.pop_front();
                        chk("rdata", {32'd0, m_rdata}, {32'd0, er});
                    end
                end else begin
                    chk("rdata_zero_idle", {32'd0, m_rdata}, 64'd0);
                end
                if (err_o) begin
                    if (eq.size() == 0) begin
                        chk("unexpected_err", {62'd0, err_code_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ee = eq.pop_front();
                        exp_cnt = (exp_cnt == (1 << ECW) - 1) ? exp_cnt : exp_cnt + 1;
                        chk("err_code", {62'd0, err_code_o}, {62'd0, ee[33:32]});
                        chk("err_addr", {32'd0, err_addr_o}, {32'd0, ee[31:0]});
                        chk("err_cnt", {60'd0, err_cnt_o}, 64'(exp_cnt));
                    end
                end
            end
        end
    end

    // One master transaction with slave behaviour described by latencies
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int acc_lat, input int rsp_lat, input logic [31:0] rdat,
                       input int cke_hold);
        int sel, exp_acc, exp_rv, got_acc, got_rv, nmax;
        bit mapped, rd, normal, ready_bad;
        logic [NS-1:0] exp_av;
        sel    = int'(a[31:30]);
        mapped = sel < NS;
        rd     = (ws == 4'd0);
        normal = mapped && acc_lat < TO;
        exp_rv = 1;
        if (!mapped) begin
            exp_acc = 0;
            eq.push_back({2'b01, a});
            if (rd) rq.push_back(ERRD);
        end else if (!normal) begin
            exp_acc = TO - 1;
            eq.push_back({2'b10, a});
            if (rd) rq.push_back(ERRD);
        end else begin
            exp_acc = acc_lat;
            if (rd) begin
                if (rsp_lat <= TO && cke_hold == 0) begin
                    exp_rv = rsp_lat;
                    rq.push_back(rdat);
                end else begin
                    exp_rv = TO + 1 + cke_hold;
                    rq.push_back(ERRD);
                    eq.push_back({2'b11, a});
                end
            end
        end

        @(posedge clk); #1;
        m_avalid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
        got_acc = -1;
        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < NS; k++)
                s_ready[k] = (k == sel) ? (mapped && c >= acc_lat) : 1'($urandom);
            #3;
            exp_av = '0;
            if (mapped && !(!normal && c == TO - 1)) exp_av[sel] = 1'b1;
            chk("slave_avalid", {61'd0, s_av}, {61'd0, exp_av});
            chk("addr_bcast", {32'd0, s_req_o[sel % NS * REQ_W + 36 +: 32]}, {32'd0, a});
            if (m_ready) begin
                got_acc = c;
                break;
            end
            @(posedge clk); #1;
        end
        chk("accept_cycle", 64'(got_acc), 64'(exp_acc));
        @(posedge clk); #1;
        m_avalid = 1'b0; s_ready = '0;
        if (!rd) return;

        got_rv = -1;
        ready_bad = 1'b0;
        nmax = ((rsp_lat > exp_rv) ? rsp_lat : exp_rv) + 2;
        for (int n = 1; n <= nmax; n++) begin
            cke_i = !(cke_hold > 0 && n >= 3 && n < 3 + cke_hold);
            for (int k = 0; k < NS; k++) begin
                if (k == sel) begin
                    s_rvalid[k] = normal && n == rsp_lat;
                    s_rdata[k]  = (normal && n == rsp_lat) ? rdat : $urandom;
                end else begin
                    s_rvalid[k] = 1'($urandom);
                    s_rdata[k]  = $urandom;
                end
            end
            #3;
            if (m_rvalid && got_rv < 0) got_rv = n;
            if (got_rv < 0 && m_ready) ready_bad = 1'b1;
            @(posedge clk); #1;
        end
        cke_i = 1'b1; s_rvalid = '0;
        chk("rvalid_cycle", 64'(got_rv), 64'(exp_rv));
        chk("ready_low_wait", {63'd0, ready_bad}, 64'd0);
    endtask

    initial begin
        arst_i = 1'b1; cke_i = 1'b1;
        m_avalid = 1'b1; m_addr = 32'h4000_0000; m_wdata = '0; m_wstrb = '0;
        s_ready = '1; s_rvalid = '1;
        for (int k = 0; k < NS; k++) s_rdata[k] = 32'hA5A5_0000 + 32'(k);
        #12;
        chk("rst_s_avalid", {61'd0, s_av}, 64'd0);
        chk("rst_m_rvalid", {63'd0, m_rvalid}, 64'd0);
        chk("rst_m_rdata", {32'd0, m_rdata}, 64'd0);
        chk("rst_err", {63'd0, err_o}, 64'd0);
        chk("rst_cnt", {60'd0, err_cnt_o}, 64'd0);
        chk("rst_code", {62'd0, err_code_o}, 64'd0);
        @(posedge clk); #1;
        m_avalid = 1'b0; s_ready = '0; s_rvalid = '0;
        arst_i = 1'b0;
        repeat (2) @(posedge clk);

        txn(32'h4000_0010, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
        txn(32'h8000_0004, 0, 4'h0, 0, 3, 32'hCAFE_F00D, 0);
        txn(32'hC000_0000, 0, 4'h0, 0, 0, 0, 0);
        txn(32'h0000_0008, 0, 4'h0, 30, 0, 0, 0);
        txn(32'h4000_0000, 0, 4'h0, 0, 20, 32'h1111_2222, 0);
        txn(32'h0000_0004, 0, 4'h0, 0, 100, 0, 10);
        txn(32'h4000_0040, 32'h0BAD_F00D, 4'h3, 2, 0, 0, 0);

        // Reset while a read is outstanding: its response must never surface
        @(posedge clk); #1;
        m_avalid = 1'b1; m_addr = 32'h4000_0020; m_wstrb = 4'h0; s_ready[1] = 1'b1;
        #3 chk("rst_mid_accept", {63'd0, m_ready}, 64'd1);
        @(posedge clk); #1;
        m_avalid = 1'b0; s_ready = '0;
        repeat (4) @(posedge clk);
        #1 arst_i = 1'b1;
        #3 chk("rst_mid_cnt", {60'd0, err_cnt_o}, 64'd0);
        @(posedge clk); #1;
        arst_i = 1'b0; s_rvalid[1] = 1'b1; s_rdata[1] = 32'h5555_AAAA;
        #3 chk("rst_mid_no_rvalid", {63'd0, m_rvalid}, 64'd0);
        @(posedge clk); #1;
        s_rvalid = '0;

        for (int i = 0; i < (1 << ECW) + 5; i++)
            txn({2'b11, 30'($urandom)}, $urandom, 4'($urandom_range(1, 15)), 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            bit rd;
            int acc, rsp;
            a   = {2'($urandom_range(0, 3)), 30'($urandom)};
            rd  = 1'($urandom);
            acc = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
            rsp = ($urandom_range(0, 9) == 0) ? 18 : $urandom_range(1, 5);
            txn(a, $urandom, rd ? 4'h0 : 4'($urandom_range(1, 15)), acc, rsp, $urandom, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("cnt_saturated", {60'd0, err_cnt_o}, 64'd15);
        chk("rq_drained", 64'(rq.size()), 64'd0);
        chk("eq_drained", 64'(eq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
